// File: rtl/data_sram_resp.sv
// Responder end of the data-side sram-like bus, fronting a single-port synchronous
// word RAM. Responses return in accept order after a fixed LATENCY cycles.
module data_sram_resp #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2,
    parameter int MAX_OUT = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              data_sram_req,
    input  logic              data_sram_wr,
    input  logic [1:0]        data_sram_size,
    input  logic [3:0]        data_sram_wstrb,
    input  logic [31:0]       data_sram_addr,
    input  logic [31:0]       data_sram_wdata,
    output logic              data_sram_addr_ok,
    output logic              data_sram_data_ok,
    output logic [31:0]       data_sram_rdata,
    input  logic              stall,
    output logic              ram_en,
    output logic [3:0]        ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

    logic              handshake;
    logic [CNT_W-1:0]  out_cnt_reg;
    logic [CNT_W-1:0]  out_cnt_next;
    logic [LATENCY:1]  valid_reg;
    logic              rd1_reg;
    logic [31:0]       stage1_word;
    logic [31:0]       resp_word;

    // Size and the address bits outside the word index carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{data_sram_size, data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

    // Acceptance uses the registered count, so a slot freed by data_ok opens next cycle.
    assign data_sram_addr_ok = data_sram_req && !stall && (out_cnt_reg < CNT_MAX) && resetn;
    assign handshake         = data_sram_req && data_sram_addr_ok;

    assign ram_en    = handshake;
    assign ram_wen   = (handshake && data_sram_wr) ? data_sram_wstrb : 4'b0000;
    assign ram_addr  = data_sram_addr[ADDR_W+1:2];
    assign ram_wdata = data_sram_wdata;

    always_comb begin
        out_cnt_next = out_cnt_reg;
        case ({handshake, data_sram_data_ok})
            2'b10:   out_cnt_next = out_cnt_reg + 1'b1;
            2'b01:   out_cnt_next = out_cnt_reg - 1'b1;
            default: out_cnt_next = out_cnt_reg;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_cnt_reg <= '0;
        end else begin
            out_cnt_reg <= out_cnt_next;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_reg <= '0;
            rd1_reg   <= 1'b0;
        end else begin
            valid_reg[1] <= handshake;
            for (int k = 2; k <= LATENCY; k++) begin
                valid_reg[k] <= valid_reg[k-1];
            end
            rd1_reg <= handshake && !data_sram_wr;
        end
    end

    // RAM data is only meaningful in the cycle right after a read strobe.
    assign stage1_word = rd1_reg ? ram_rdata : 32'h0;

    generate
        if (LATENCY == 1) begin : g_comb
            assign resp_word = valid_reg[1] ? stage1_word : 32'h0;
        end else begin : g_pipe
            logic [31:0] word_reg [LATENCY:2];

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    for (int k = 2; k <= LATENCY; k++) begin
                        word_reg[k] <= '0;
                    end
                end else begin
                    word_reg[2] <= valid_reg[1] ? stage1_word : 32'h0;
                    for (int k = 3; k <= LATENCY; k++) begin
                        word_reg[k] <= valid_reg[k-1] ? word_reg[k-1] : 32'h0;
                    end
                end
            end

            assign resp_word = valid_reg[LATENCY] ? word_reg[LATENCY] : 32'h0;
        end
    endgenerate

    assign data_sram_data_ok = valid_reg[LATENCY];
    assign data_sram_rdata   = resp_word;

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed and random checks of data_sram_resp across four LATENCY/MAX_OUT builds,
// each backed by its own synchronous RAM model.
module tb_data_sram_resp;

    localparam int N  = 4;
    localparam int AW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn;

    logic          req_s   [N];
    logic          wr_s    [N];
    logic [1:0]    size_s  [N];
    logic [3:0]    wstrb_s [N];
    logic [31:0]   addr_s  [N];
    logic [31:0]   wdata_s [N];
    logic          stall_s [N];

    logic          addr_ok_s   [N];
    logic          data_ok_s   [N];
    logic [31:0]   rdata_s     [N];
    logic          ram_en_s    [N];
    logic [3:0]    ram_wen_s   [N];
    logic [AW-1:0] ram_addr_s  [N];
    logic [3:0]    out_cnt_s   [N];

    int n_vec = 0;
    int n_err = 0;

    // Instance 0: LAT2/MO2, 1: LAT2/MO1, 2: LAT1/MO4, 3: LAT4/MO4.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_dut
            localparam int LAT = (gi == 3) ? 4 : ((gi == 2) ? 1 : 2);
            localparam int MO  = (gi == 1) ? 1 : ((gi >= 2) ? 4 : 2);

            logic [31:0]   mem [0:255] = '{default: '0};
            logic [31:0]   rd_q = '0;
            logic          addr_ok_w, data_ok_w, ram_en_w;
            logic [31:0]   rdata_w, ram_wdata_w;
            logic [3:0]    ram_wen_w;
            logic [AW-1:0] ram_addr_w;

            data_sram_resp #(.ADDR_W(AW), .LATENCY(LAT), .MAX_OUT(MO)) u_dut (
                .clk               (clk),
                .resetn            (resetn),
                .data_sram_req     (req_s[gi]),
                .data_sram_wr      (wr_s[gi]),
                .data_sram_size    (size_s[gi]),
                .data_sram_wstrb   (wstrb_s[gi]),
                .data_sram_addr    (addr_s[gi]),
                .data_sram_wdata   (wdata_s[gi]),
                .data_sram_addr_ok (addr_ok_w),
                .data_sram_data_ok (data_ok_w),
                .data_sram_rdata   (rdata_w),
                .stall             (stall_s[gi]),
                .ram_en            (ram_en_w),
                .ram_wen           (ram_wen_w),
                .ram_addr          (ram_addr_w),
                .ram_wdata         (ram_wdata_w),
                .ram_rdata         (rd_q)
            );

            always @(posedge clk) begin
                if (ram_en_w) begin
                    rd_q <= mem[ram_addr_w];
                    for (int b = 0; b < 4; b++) begin
                        if (ram_wen_w[b]) mem[ram_addr_w][b*8 +: 8] <= ram_wdata_w[b*8 +: 8];
                    end
                end
            end

            assign addr_ok_s[gi]  = addr_ok_w;
            assign data_ok_s[gi]  = data_ok_w;
            assign rdata_s[gi]    = rdata_w;
            assign ram_en_s[gi]   = ram_en_w;
            assign ram_wen_s[gi]  = ram_wen_w;
            assign ram_addr_s[gi] = ram_addr_w;
            assign out_cnt_s[gi]  = 4'(u_dut.out_cnt_reg);
        end
    endgenerate

    task automatic drive(input int k, input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        req_s[k]   = r;
        wr_s[k]    = w;
        addr_s[k]  = a;
        wdata_s[k] = d;
        wstrb_s[k] = s;
        size_s[k]  = 2'd2;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int lat_of(input int k);
        return (k == 3) ? 4 : ((k == 2) ? 1 : 2);
    endfunction

    function automatic int mo_of(input int k);
        return (k == 1) ? 1 : ((k >= 2) ? 4 : 2);
    endfunction

    task automatic test_reset();
        resetn = 1'b0;
        for (int k = 0; k < N; k++) begin
            drive(k, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            stall_s[k] = 1'b0;
        end
        drive(0, 1'b1, 1'b1, 32'h10, 32'h1234_5678, 4'hF);
        step();
        step();
        @(negedge clk);
        n_vec++; if (addr_ok_s[0] !== 1'b0) begin n_err++; $display("FAIL reset_addr_ok: got %b want 0", addr_ok_s[0]); end
        n_vec++; if (data_ok_s[0] !== 1'b0) begin n_err++; $display("FAIL reset_data_ok: got %b want 0", data_ok_s[0]); end
        n_vec++; if (rdata_s[0] !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", rdata_s[0]); end
        n_vec++; if (ram_en_s[0] !== 1'b0) begin n_err++; $display("FAIL reset_ram_en: got %b want 0", ram_en_s[0]); end
        n_vec++; if (ram_wen_s[0] !== 4'h0) begin n_err++; $display("FAIL reset_ram_wen: got %h want 0", ram_wen_s[0]); end
        n_vec++; if (out_cnt_s[0] !== 4'd0) begin n_err++; $display("FAIL reset_out_cnt: got %0d want 0", out_cnt_s[0]); end
        $display("reset: outputs idle while resetn low");
        step();
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        resetn = 1'b1;
    endtask

    task automatic test_write_read();
        drive(0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
        @(negedge clk);
        n_vec++; if (addr_ok_s[0] !== 1'b1) begin n_err++; $display("FAIL wr_addr_ok: got %b want 1", addr_ok_s[0]); end
        n_vec++; if (ram_wen_s[0] !== 4'hF) begin n_err++; $display("FAIL wr_ram_wen: got %h want f", ram_wen_s[0]); end
        n_vec++; if (ram_addr_s[0] !== 8'h04) begin n_err++; $display("FAIL wr_ram_addr: got %h want 04", ram_addr_s[0]); end
        step();
        drive(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        @(negedge clk);
        n_vec++; if (addr_ok_s[0] !== 1'b1) begin n_err++; $display("FAIL rd_addr_ok: got %b want 1", addr_ok_s[0]); end
        n_vec++; if (ram_wen_s[0] !== 4'h0) begin n_err++; $display("FAIL rd_ram_wen: got %h want 0", ram_wen_s[0]); end
        n_vec++; if (data_ok_s[0] !== 1'b0) begin n_err++; $display("FAIL wr_early_data_ok: got %b want 0", data_ok_s[0]); end
        step();
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        n_vec++; if (data_ok_s[0] !== 1'b1) begin n_err++; $display("FAIL wr_resp_data_ok: got %b want 1", data_ok_s[0]); end
        n_vec++; if (rdata_s[0] !== 32'h0) begin n_err++; $display("FAIL wr_resp_rdata: got %h want 0", rdata_s[0]); end
        n_vec++; if (ram_en_s[0] !== 1'b0) begin n_err++; $display("FAIL idle_ram_en: got %b want 0", ram_en_s[0]); end
        $display("write 0x10 response rdata=%h", rdata_s[0]);
        step();
        @(negedge clk);
        n_vec++; if (data_ok_s[0] !== 1'b1) begin n_err++; $display("FAIL rd_resp_data_ok: got %b want 1", data_ok_s[0]); end
        n_vec++; if (rdata_s[0] !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rd_resp_rdata: got %h want deadbeef", rdata_s[0]); end
        $display("read 0x10 response rdata=%h", rdata_s[0]);
        step();
        @(negedge clk);
        n_vec++; if (data_ok_s[0] !== 1'b0) begin n_err++; $display("FAIL wrrd_tail_data_ok: got %b want 0", data_ok_s[0]); end
        n_vec++; if (rdata_s[0] !== 32'h0) begin n_err++; $display("FAIL wrrd_tail_rdata: got %h want 0", rdata_s[0]); end
        step();
    endtask

    // Third request arrives while the count sits at MAX_OUT with a data_ok in flight.
    task automatic test_byte_lanes();
        drive(0, 1'b1, 1'b1, 32'h20, 32'h1122_3344, 4'hF);
        @(negedge clk);
        n_vec++; if (addr_ok_s[0] !== 1'b1) begin n_err++; $display("FAIL lanes_w1_addr_ok: got %b want 1", addr_ok_s[0]); end
        step();
        drive(0, 1'b1, 1'b1, 32'h20, 32'h00AA_0000, 4'b0100);
        @(negedge clk);
        n_vec++; if (addr_ok_s[0] !== 1'b1) begin n_err++; $display("FAIL lanes_w2_addr_ok: got %b want 1", addr_ok_s[0]); end
        step();
        drive(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        @(negedge clk);
        n_vec++; if (out_cnt_s[0] !== 4'd2) begin n_err++; $display("FAIL lanes_cnt_full: got %0d want 2", out_cnt_s[0]); end
        n_vec++; if (addr_ok_s[0] !== 1'b0) begin n_err++; $display("FAIL limit_addr_ok: got %b want 0", addr_ok_s[0]); end
        n_vec++; if (data_ok_s[0] !== 1'b1) begin n_err++; $display("FAIL lanes_w1_data_ok: got %b want 1", data_ok_s[0]); end
        step();
        @(negedge clk);
        n_vec++; if (addr_ok_s[0] !== 1'b1) begin n_err++; $display("FAIL freed_slot_addr_ok: got %b want 1", addr_ok_s[0]); end
        n_vec++; if (data_ok_s[0] !== 1'b1) begin n_err++; $display("FAIL lanes_w2_data_ok: got %b want 1", data_ok_s[0]); end
        step();
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        n_vec++; if (data_ok_s[0] !== 1'b0) begin n_err++; $display("FAIL lanes_gap_data_ok: got %b want 0", data_ok_s[0]); end
        step();
        @(negedge clk);
        n_vec++; if (data_ok_s[0] !== 1'b1) begin n_err++; $display("FAIL lanes_rd_data_ok: got %b want 1", data_ok_s[0]); end
        n_vec++; if (rdata_s[0] !== 32'h11AA_3344) begin n_err++; $display("FAIL lanes_rdata: got %h want 11aa3344", rdata_s[0]); end
        $display("read 0x20 after lane write rdata=%h", rdata_s[0]);
        step();
    endtask

    // 8 writes then 8 reads with req held. A slot freed by data_ok is reusable one
    // cycle later, so accept j lands in cycle (j/nacc)*period + j%nacc.
    task automatic test_back_to_back(input int k, input int period, input int nacc, input int lat);
        int acc;
        int rsp;
        int jdok;
        logic exp_aok;
        logic [31:0] exp_rd;
        acc = 0;
        rsp = 0;
        for (int c = 0; c < 80 && rsp < 16; c++) begin
            if (acc < 16)
                drive(k, 1'b1, (acc < 8), 32'h80 + 32'(4 * (acc % 8)),
                      32'hA000_0000 + 32'(k << 16) + 32'(acc % 8), 4'hF);
            else
                drive(k, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            @(negedge clk);
            exp_aok = (acc < 16) && ((c % period) < nacc);
            n_vec++;
            if (addr_ok_s[k] !== exp_aok) begin
                n_err++; $display("FAIL b2b_addr_ok inst%0d cyc%0d: got %b want %b", k, c, addr_ok_s[k], exp_aok);
            end
            jdok = -1;
            for (int j = 0; j < 16; j++) begin
                if ((j / nacc) * period + (j % nacc) + lat == c) jdok = j;
            end
            n_vec++;
            if (data_ok_s[k] !== (jdok >= 0)) begin
                n_err++; $display("FAIL b2b_data_ok inst%0d cyc%0d: got %b want %b", k, c, data_ok_s[k], (jdok >= 0));
            end
            if (jdok >= 0) begin
                exp_rd = (jdok < 8) ? 32'h0 : 32'hA000_0000 + 32'(k << 16) + 32'(jdok - 8);
                n_vec++;
                if (rdata_s[k] !== exp_rd) begin
                    n_err++; $display("FAIL b2b_rdata inst%0d rsp%0d: got %h want %h", k, jdok, rdata_s[k], exp_rd);
                end
                $display("b2b inst%0d rsp%0d rdata=%h", k, jdok, rdata_s[k]);
                rsp++;
            end
            if (addr_ok_s[k] === 1'b1 && acc < 16) acc++;
            step();
        end
        n_vec++;
        if (acc != 16) begin n_err++; $display("FAIL b2b_accepts inst%0d: got %0d want 16", k, acc); end
    endtask

    task automatic test_stall();
        drive(0, 1'b1, 1'b0, 32'h80, 32'h0, 4'h0);
        @(negedge clk);
        n_vec++; if (addr_ok_s[0] !== 1'b1) begin n_err++; $display("FAIL stall_pre_addr_ok: got %b want 1", addr_ok_s[0]); end
        step();
        drive(0, 1'b1, 1'b0, 32'h84, 32'h0, 4'h0);
        stall_s[0] = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            n_vec++; if (addr_ok_s[0] !== 1'b0) begin n_err++; $display("FAIL stall_addr_ok cyc%0d: got %b want 0", c, addr_ok_s[0]); end
            n_vec++; if (data_ok_s[0] !== (c == 2)) begin n_err++; $display("FAIL stall_data_ok cyc%0d: got %b want %b", c, data_ok_s[0], (c == 2)); end
            if (c == 2) begin
                n_vec++; if (rdata_s[0] !== 32'hA000_0000) begin n_err++; $display("FAIL stall_rdata: got %h want a0000000", rdata_s[0]); end
                $display("stall in-flight rsp rdata=%h", rdata_s[0]);
            end
            step();
        end
        stall_s[0] = 1'b0;
        @(negedge clk);
        n_vec++; if (addr_ok_s[0] !== 1'b1) begin n_err++; $display("FAIL unstall_addr_ok: got %b want 1", addr_ok_s[0]); end
        step();
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        n_vec++; if (data_ok_s[0] !== 1'b0) begin n_err++; $display("FAIL unstall_gap_data_ok: got %b want 0", data_ok_s[0]); end
        step();
        @(negedge clk);
        n_vec++; if (rdata_s[0] !== 32'hA000_0001 || data_ok_s[0] !== 1'b1) begin
            n_err++; $display("FAIL unstall_rsp: got ok=%b %h want ok=1 a0000001", data_ok_s[0], rdata_s[0]);
        end
        step();
    endtask

    task automatic test_reset_midflight();
        drive(0, 1'b1, 1'b0, 32'h80, 32'h0, 4'h0);
        step();
        drive(0, 1'b1, 1'b0, 32'h84, 32'h0, 4'h0);
        @(negedge clk);
        n_vec++; if (addr_ok_s[0] !== 1'b1) begin n_err++; $display("FAIL mid_second_accept: got %b want 1", addr_ok_s[0]); end
        step();
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        resetn = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c == 2) resetn = 1'b1;
            @(negedge clk);
            n_vec++; if (data_ok_s[0] !== 1'b0) begin n_err++; $display("FAIL mid_dropped_data_ok cyc%0d: got %b want 0", c, data_ok_s[0]); end
            n_vec++; if (out_cnt_s[0] !== 4'd0) begin n_err++; $display("FAIL mid_out_cnt cyc%0d: got %0d want 0", c, out_cnt_s[0]); end
            step();
        end
        drive(0, 1'b1, 1'b0, 32'h88, 32'h0, 4'h0);
        @(negedge clk);
        n_vec++; if (addr_ok_s[0] !== 1'b1) begin n_err++; $display("FAIL post_rst_addr_ok: got %b want 1", addr_ok_s[0]); end
        step();
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        n_vec++; if (data_ok_s[0] !== 1'b0) begin n_err++; $display("FAIL post_rst_early: got %b want 0", data_ok_s[0]); end
        step();
        @(negedge clk);
        n_vec++; if (data_ok_s[0] !== 1'b1 || rdata_s[0] !== 32'hA000_0002) begin
            n_err++; $display("FAIL post_rst_rsp: got ok=%b %h want ok=1 a0000002", data_ok_s[0], rdata_s[0]);
        end
        $display("post-reset read 0x88 rdata=%h", rdata_s[0]);
        step();
    endtask

    // Random traffic on the LAT1 and LAT4 builds against a word-memory reference.
    logic [31:0] ref_mem [N][256];
    logic [31:0] rq_data [N][64];
    int          rq_due  [N][64];

    task automatic test_sweep();
        int head [N];
        int tail [N];
        int mcnt [N];
        logic pend [N];
        logic exp_dok, exp_aok, hs;
        logic [31:0] exp_rd, word;
        int widx;
        for (int k = 0; k < N; k++) begin
            head[k] = 0; tail[k] = 0; mcnt[k] = 0; pend[k] = 1'b0;
            for (int i = 0; i < 256; i++) ref_mem[k][i] = 32'h0;
        end
        for (int cyc = 0; cyc < 220; cyc++) begin
            for (int k = 2; k < N; k++) begin
                if (!pend[k]) begin
                    req_s[k]   = (cyc < 200) && ($urandom_range(0, 9) < 7);
                    wr_s[k]    = 1'($urandom_range(0, 1));
                    wstrb_s[k] = 4'($urandom_range(0, 15));
                    wdata_s[k] = $urandom;
                    addr_s[k]  = ($urandom & 32'hFFFF_FC03) | (32'($urandom_range(0, 15)) << 2);
                    size_s[k]  = 2'($urandom_range(0, 2));
                end
                stall_s[k] = ($urandom_range(0, 4) == 0);
            end
            @(negedge clk);
            for (int k = 2; k < N; k++) begin
                exp_dok = (head[k] != tail[k]) && (rq_due[k][head[k] % 64] == cyc);
                n_vec++;
                if (data_ok_s[k] !== exp_dok) begin
                    n_err++; $display("FAIL sweep_data_ok inst%0d cyc%0d: got %b want %b", k, cyc, data_ok_s[k], exp_dok);
                end
                exp_rd = exp_dok ? rq_data[k][head[k] % 64] : 32'h0;
                n_vec++;
                if (rdata_s[k] !== exp_rd) begin
                    n_err++; $display("FAIL sweep_rdata inst%0d cyc%0d: got %h want %h", k, cyc, rdata_s[k], exp_rd);
                end
                if (exp_dok) begin
                    $display("sweep inst%0d rsp%0d rdata=%h", k, head[k], rdata_s[k]);
                    head[k]++;
                end
                exp_aok = req_s[k] && !stall_s[k] && (mcnt[k] < mo_of(k));
                n_vec++;
                if (addr_ok_s[k] !== exp_aok) begin
                    n_err++; $display("FAIL sweep_addr_ok inst%0d cyc%0d: got %b want %b", k, cyc, addr_ok_s[k], exp_aok);
                end
                hs = req_s[k] && (addr_ok_s[k] === 1'b1);
                if (hs) begin
                    n_vec++;
                    if (out_cnt_s[k] >= 4'(mo_of(k))) begin
                        n_err++; $display("FAIL sweep_accept_at_limit inst%0d cyc%0d: out_cnt %0d limit %0d", k, cyc, out_cnt_s[k], mo_of(k));
                    end
                    widx = int'(addr_s[k][AW+1:2]);
                    word = ref_mem[k][widx];
                    if (wr_s[k]) begin
                        for (int b = 0; b < 4; b++)
                            if (wstrb_s[k][b]) word[b*8 +: 8] = wdata_s[k][b*8 +: 8];
                        ref_mem[k][widx] = word;
                        rq_data[k][tail[k] % 64] = 32'h0;
                    end else begin
                        rq_data[k][tail[k] % 64] = word;
                    end
                    rq_due[k][tail[k] % 64] = cyc + lat_of(k);
                    tail[k]++;
                end
                mcnt[k] = mcnt[k] + (hs ? 1 : 0) - (exp_dok ? 1 : 0);
                pend[k] = req_s[k] && !hs;
            end
            step();
        end
        for (int k = 2; k < N; k++) begin
            n_vec++;
            if (head[k] != tail[k]) begin
                n_err++; $display("FAIL sweep_drain inst%0d: %0d responses missing", k, tail[k] - head[k]);
            end
            req_s[k] = 1'b0;
            stall_s[k] = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_back_to_back(0, 3, 2, 2);
        test_back_to_back(1, 3, 1, 2);
        test_back_to_back(2, 1, 1, 1);
        test_stall();
        test_reset_midflight();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
